// File: rtl/group_packer.sv
// Packs a stream of GROUP_W-bit groups into GROUPS-group words, group k at bits [k*GROUP_W +: GROUP_W].
// A one-deep output register lets the next word accumulate while the consumer drains the current one.
module group_packer #(
    parameter int GROUP_W = 10,
    parameter int GROUPS  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [GROUP_W-1:0]        i_d,
    input  logic                      i_in_valid,
    input  logic                      i_in_last,
    output logic                      o_in_ready,
    output logic [GROUP_W*GROUPS-1:0] o_y,
    output logic [2:0]                o_n,
    output logic                      o_out_valid,
    input  logic                      i_out_ready
);
    localparam int WORD_W = GROUP_W * GROUPS;

    logic [WORD_W-1:0] r_acc;
    logic [1:0]        r_cnt;
    logic [WORD_W-1:0] r_y;
    logic [2:0]        r_n;
    logic              r_out_valid;

    logic              w_slot_free;
    logic              w_closes;
    logic              w_accept;
    logic              w_complete;
    logic [WORD_W-1:0] w_merged;

    assign w_slot_free = !r_out_valid | i_out_ready;
    assign w_closes    = (r_cnt == 2'(GROUPS - 1)) | i_in_last;
    assign o_in_ready  = w_slot_free | !w_closes;
    assign w_accept    = i_in_valid & o_in_ready;
    assign w_complete  = w_accept & w_closes;

    // Slot cnt takes D; slots above it are forced to zero so a short word never carries stale data.
    always_comb begin
        w_merged = '0;
        for (int g = 0; g < GROUPS; g++) begin
            if (g == int'(r_cnt)) begin
                w_merged[g*GROUP_W +: GROUP_W] = i_d;
            end else if (g < int'(r_cnt)) begin
                w_merged[g*GROUP_W +: GROUP_W] = r_acc[g*GROUP_W +: GROUP_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_y         <= '0;
            r_n         <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (r_out_valid && i_out_ready && !w_complete) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept) begin
                if (w_closes) begin
                    r_y         <= w_merged;
                    r_n         <= {1'b0, r_cnt} + 3'd1;
                    r_out_valid <= 1'b1;
                    r_acc       <= '0;
                    r_cnt       <= '0;
                end else begin
                    r_acc <= w_merged;
                    r_cnt <= r_cnt + 2'd1;
                end
            end
        end
    end

    assign o_y         = r_y;
    assign o_n         = r_n;
    assign o_out_valid = r_out_valid;

endmodule

// File: tb/tb_group_packer.sv
// Randomized and directed bench for group_packer against a queue-based word model,
// plus a round-trip through the 4-group selector Y = (X >> A*10)[9:0].
module tb_group_packer;
    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  i_d;
    logic        i_in_valid;
    logic        i_in_last;
    logic        o_in_ready;
    logic [39:0] o_y;
    logic [2:0]  o_n;
    logic        o_out_valid;
    logic        i_out_ready;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    group_packer #(.GROUP_W(10), .GROUPS(4)) dut (
        .clk(clk), .rst(rst), .i_d(i_d), .i_in_valid(i_in_valid), .i_in_last(i_in_last),
        .o_in_ready(o_in_ready), .o_y(o_y), .o_n(o_n), .o_out_valid(o_out_valid),
        .i_out_ready(i_out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] sel(input logic [39:0] x, input int a);
        logic [39:0] s;
        s = x >> (a * 10);
        return s[9:0];
    endfunction

    function automatic logic [39:0] pack4(input int g0, input int g1, input int g2, input int g3);
        return 40'(g0) + (40'(g1) << 10) + (40'(g2) << 20) + (40'(g3) << 30);
    endfunction

    // Reference model: the open word is a queue of accepted groups; the output is one held word.
    int          m_q[$];
    logic [39:0] m_y;
    logic [2:0]  m_n;
    bit          m_ov;

    always @(posedge clk or posedge rst) begin
        bit rdy, acc, done, drain;
        logic [39:0] w;
        if (rst) begin
            m_q.delete();
            m_y  = '0;
            m_n  = '0;
            m_ov = 0;
        end else begin
            rdy   = !m_ov || i_out_ready || (m_q.size() != 3 && !i_in_last);
            acc   = i_in_valid && rdy;
            drain = m_ov && i_out_ready;
            done  = 0;
            if (acc) begin
                m_q.push_back(int'(i_d));
                if (m_q.size() == 4 || i_in_last) begin
                    w = '0;
                    foreach (m_q[k]) w = w | (40'(m_q[k]) << (10 * k));
                    m_y  = w;
                    m_n  = 3'(m_q.size());
                    m_ov = 1;
                    done = 1;
                    m_q.delete();
                end
            end
            if (drain && !done) m_ov = 0;
        end
    end

    always @(negedge clk) begin
        bit exp_rdy;
        if (!rst && chk_en) begin
            exp_rdy = !m_ov || i_out_ready || (m_q.size() != 3 && !i_in_last);
            check("out_valid", 64'(o_out_valid), 64'(m_ov));
            check("y", 64'(o_y), 64'(m_y));
            check("n", 64'(o_n), 64'(m_n));
            check("in_ready", 64'(o_in_ready), 64'(exp_rdy));
        end
    end

    task automatic send(input logic [9:0] d, input logic last);
        i_in_valid = 1'b1;
        i_d        = d;
        i_in_last  = last;
        @(posedge clk); #1;
        i_in_valid = 1'b0;
        i_in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        int ov_cnt;
        logic [9:0] g[4];
        logic [39:0] w1, w2;
        bit hold;

        rst = 1'b1; i_d = '0; i_in_valid = 1'b0; i_in_last = 1'b0; i_out_ready = 1'b0;
        #2;
        check("reset_y", 64'(o_y), 64'h0);
        check("reset_n", 64'(o_n), 64'h0);
        check("reset_out_valid", 64'(o_out_valid), 64'h0);
        check("reset_in_ready", 64'(o_in_ready), 64'h1);
        #10 rst = 1'b0;
        chk_en = 1;
        @(posedge clk); #1;

        // Full word
        i_out_ready = 1'b1;
        send(10'h001, 0); send(10'h002, 0); send(10'h003, 0); send(10'h004, 0);
        check("full_y", 64'(o_y), 64'h0100300801);
        check("full_n", 64'(o_n), 64'd4);
        check("full_valid", 64'(o_out_valid), 64'd1);
        idle(1);
        check("full_valid_one_cycle", 64'(o_out_valid), 64'd0);

        // Partial word, then a zero word proving no stale upper groups
        send(10'h3FF, 0); send(10'h155, 1);
        check("partial_y", 64'(o_y), 64'h00000557FF);
        check("partial_n", 64'(o_n), 64'd2);
        idle(1);
        send(10'h000, 0); send(10'h000, 0); send(10'h000, 0); send(10'h000, 0);
        check("zero_y", 64'(o_y), 64'h0);
        check("zero_n", 64'(o_n), 64'd4);
        idle(1);

        // Backpressure
        i_out_ready = 1'b0;
        w1 = pack4('h011, 'h012, 'h013, 'h014);
        w2 = pack4('h021, 'h022, 'h023, 'h024);
        send(10'h011, 0); send(10'h012, 0); send(10'h013, 0); send(10'h014, 0);
        check("bp_w1", 64'(o_y), 64'(w1));
        send(10'h021, 0); send(10'h022, 0); send(10'h023, 0);
        check("bp_w1_stable", 64'(o_y), 64'(w1));
        check("bp_valid", 64'(o_out_valid), 64'd1);
        i_in_valid = 1'b1; i_d = 10'h024; i_in_last = 1'b0;
        #1 check("bp_stall_ready", 64'(o_in_ready), 64'd0);
        @(posedge clk); #1;
        check("bp_stall_hold_y", 64'(o_y), 64'(w1));
        check("bp_stall_ready2", 64'(o_in_ready), 64'd0);
        i_out_ready = 1'b1;
        #1 check("bp_release_ready", 64'(o_in_ready), 64'd1);
        @(posedge clk); #1;
        i_in_valid = 1'b0; i_out_ready = 1'b0;
        check("bp_w2", 64'(o_y), 64'(w2));
        check("bp_w2_n", 64'(o_n), 64'd4);
        check("bp_w2_valid", 64'(o_out_valid), 64'd1);
        check("bp_ready_after", 64'(o_in_ready), 64'd1);
        i_out_ready = 1'b1;
        idle(1);

        // Back-to-back, no bubble
        ov_cnt = 0;
        for (int k = 1; k <= 12; k++) begin
            send(10'(k), 0);
            check("b2b_valid", 64'(o_out_valid), 64'((k % 4) == 0));
            if (o_out_valid) begin
                ov_cnt++;
                check("b2b_n", 64'(o_n), 64'd4);
            end
        end
        check("b2b_words", 64'(ov_cnt), 64'd3);
        idle(1);

        // Asynchronous reset mid-word with a word pending
        i_out_ready = 1'b0;
        send(10'h101, 0); send(10'h102, 0); send(10'h103, 0); send(10'h104, 0);
        send(10'h105, 0); send(10'h106, 0);
        #3 rst = 1'b1;
        #1;
        check("rst_valid", 64'(o_out_valid), 64'd0);
        check("rst_n", 64'(o_n), 64'd0);
        check("rst_y", 64'(o_y), 64'd0);
        check("rst_ready", 64'(o_in_ready), 64'd1);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        i_out_ready = 1'b1;
        send(10'h201, 0); send(10'h202, 0); send(10'h203, 0); send(10'h204, 0);
        check("rst_clean_y", 64'(o_y), 64'(pack4('h201, 'h202, 'h203, 'h204)));
        check("rst_clean_n", 64'(o_n), 64'd4);
        idle(1);

        // Round-trip through the group selector
        for (int w = 0; w < 6; w++) begin
            for (int a = 0; a < 4; a++) g[a] = 10'($urandom_range(0, 1023));
            for (int a = 0; a < 4; a++) send(g[a], 0);
            for (int a = 0; a < 4; a++) check("roundtrip", 64'(sel(o_y, a)), 64'(g[a]));
        end
        idle(1);

        // Randomized traffic; a stalled group is held until accepted
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!hold) begin
                i_in_valid = ($urandom_range(0, 9) < 7);
                i_in_last  = ($urandom_range(0, 9) < 2);
                i_d        = 10'($urandom_range(0, 1023));
            end
            i_out_ready = ($urandom_range(0, 9) < 6);
            @(negedge clk);
            hold = i_in_valid && !o_in_ready;
            @(posedge clk); #1;
        end
        i_in_valid = 1'b0; i_in_last = 1'b0; i_out_ready = 1'b1;
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
